// File: rtl/bw_io_ddr_rptr_pipe_if.sv
// Bundle carried by one DDR repeater pipe segment: controller-side request
// signals plus the retimed outputs and status.
interface bw_io_ddr_rptr_pipe_if #(
  parameter int unsigned WIDTH = 32
);
  logic             mode_byp;
  logic             hold;
  logic             in_vld;
  logic [WIDTH-1:0] in_data;
  logic             in_par;
  logic             par_err_clr;
  logic             out_vld;
  logic [WIDTH-1:0] out_data;
  logic             out_par;
  logic             ready;
  logic             par_err;

  modport master (
    output mode_byp, hold, in_vld, in_data, in_par, par_err_clr,
    input  out_vld, out_data, out_par, ready, par_err
  );

  modport slave (
    input  mode_byp, hold, in_vld, in_data, in_par, par_err_clr,
    output out_vld, out_data, out_par, ready, par_err
  );
endinterface

// File: rtl/bw_io_ddr_rptr_pipe.sv
// Retimed DDR repeater: STAGES-deep valid/data/parity pipe with combinational
// bypass, global hold, fill tracking and a sticky output parity check.
module bw_io_ddr_rptr_pipe #(
  parameter int unsigned WIDTH  = 32,
  parameter int unsigned STAGES = 2
) (
  input logic                   rclk,
  input logic                   arst_l,
  bw_io_ddr_rptr_pipe_if.slave  io
);
  localparam int unsigned CW = $clog2(STAGES + 1);

  logic             vld_q  [STAGES];
  logic [WIDTH-1:0] data_q [STAGES];
  logic             par_q  [STAGES];
  logic [CW-1:0]    fill_q;
  logic             mode_q;
  logic             par_err_q;
  logic             flush;
  logic             adv;
  logic             err_now;

  // A mode change is seen for one edge; that edge invalidates in-flight beats.
  assign flush = io.mode_byp ^ mode_q;
  // Stages move unless frozen; bypass ignores hold and flush overrides it.
  assign adv   = io.mode_byp | ~io.hold | flush;

  // Stage 0 captures the input bundle.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      vld_q[0]  <= 1'b0;
      data_q[0] <= '0;
      par_q[0]  <= 1'b0;
    end else if (adv) begin
      vld_q[0]  <= io.in_vld & ~flush;
      data_q[0] <= io.in_data;
      par_q[0]  <= io.in_par;
    end
  end

  for (genvar s = 1; s < STAGES; s++) begin : g_stage
    // Stage s captures stage s-1.
    always_ff @(posedge rclk or negedge arst_l) begin
      if (!arst_l) begin
        vld_q[s]  <= 1'b0;
        data_q[s] <= '0;
        par_q[s]  <= 1'b0;
      end else if (adv) begin
        vld_q[s]  <= vld_q[s-1] & ~flush;
        data_q[s] <= data_q[s-1];
        par_q[s]  <= par_q[s-1];
      end
    end
  end

  // Mode tracker; it follows mode_byp through reset so release never flushes.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      mode_q <= io.mode_byp;
    end else begin
      mode_q <= io.mode_byp;
    end
  end

  // Fill counter: counts non-hold edges since reset/flush, saturating at STAGES.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      fill_q <= '0;
    end else if (io.mode_byp || flush) begin
      fill_q <= '0;
    end else if (!io.hold && (fill_q != CW'(STAGES))) begin
      fill_q <= fill_q + 1'b1;
    end
  end

  assign err_now = io.out_vld & (^{io.out_data, io.out_par});

  // Sticky parity error: a new error beats a simultaneous clear; frozen under hold.
  always_ff @(posedge rclk or negedge arst_l) begin
    if (!arst_l) begin
      par_err_q <= 1'b0;
    end else if (io.mode_byp || !io.hold) begin
      if (err_now) begin
        par_err_q <= 1'b1;
      end else if (io.par_err_clr) begin
        par_err_q <= 1'b0;
      end
    end
  end

  // Output select: input straight through in bypass, last stage otherwise.
  always_comb begin
    io.out_vld  = vld_q[STAGES-1];
    io.out_data = data_q[STAGES-1];
    io.out_par  = par_q[STAGES-1];
    io.ready    = (fill_q == CW'(STAGES));
    io.par_err  = par_err_q;
    if (io.mode_byp) begin
      io.out_vld  = io.in_vld;
      io.out_data = io.in_data;
      io.out_par  = io.in_par;
      io.ready    = 1'b1;
    end
  end
endmodule

// File: tb/tb_bw_io_ddr_rptr_pipe.sv
// Bench for bw_io_ddr_rptr_pipe: three instances (2/32, 1/8, 4/8) driven by
// one directed stream, checked every cycle against a queue model plus
// hand-computed literal expectations.
module tb_bw_io_ddr_rptr_pipe;
  localparam int unsigned NI = 3;

  logic        clk = 1'b0;
  logic        arst_l = 1'b0;
  logic        mode = 1'b0;
  logic        hold = 1'b0;
  logic        vld = 1'b0;
  logic        clr = 1'b0;
  logic        bad = 1'b0;
  logic [31:0] din = '0;
  logic        started = 1'b0;
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  bw_io_ddr_rptr_pipe_if #(.WIDTH(32)) if0 ();
  bw_io_ddr_rptr_pipe_if #(.WIDTH(8))  if1 ();
  bw_io_ddr_rptr_pipe_if #(.WIDTH(8))  if2 ();

  assign if0.mode_byp = mode;  assign if1.mode_byp = mode;  assign if2.mode_byp = mode;
  assign if0.hold = hold;      assign if1.hold = hold;      assign if2.hold = hold;
  assign if0.in_vld = vld;     assign if1.in_vld = vld;     assign if2.in_vld = vld;
  assign if0.par_err_clr = clr;
  assign if1.par_err_clr = clr;
  assign if2.par_err_clr = clr;
  assign if0.in_data = din;
  assign if1.in_data = din[7:0];
  assign if2.in_data = din[7:0];
  assign if0.in_par = (^din) ^ bad;
  assign if1.in_par = (^din[7:0]) ^ bad;
  assign if2.in_par = (^din[7:0]) ^ bad;

  bw_io_ddr_rptr_pipe #(.WIDTH(32), .STAGES(2)) u0 (.rclk(clk), .arst_l(arst_l), .io(if0));
  bw_io_ddr_rptr_pipe #(.WIDTH(8),  .STAGES(1)) u1 (.rclk(clk), .arst_l(arst_l), .io(if1));
  bw_io_ddr_rptr_pipe #(.WIDTH(8),  .STAGES(4)) u2 (.rclk(clk), .arst_l(arst_l), .io(if2));

  // ---------------- model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] d;
    logic        p;
  } beat_t;

  beat_t       pq [NI][$];
  int unsigned fill_m [NI];
  logic        perr_m [NI];
  logic        mq;

  function automatic int unsigned stg(int unsigned i);
    return (i == 0) ? 2 : ((i == 1) ? 1 : 4);
  endfunction

  function automatic logic [31:0] msk(int unsigned i);
    return (i == 0) ? 32'hFFFF_FFFF : 32'h0000_00FF;
  endfunction

  function automatic beat_t in_beat(int unsigned i);
    beat_t b;
    b.v = vld;
    b.d = din & msk(i);
    b.p = (^(din & msk(i))) ^ bad;
    return b;
  endfunction

  // {vld, par, ready, par_err, data}
  function automatic logic [35:0] exp_out(int unsigned i);
    beat_t b;
    logic  rdy;
    b   = mode ? in_beat(i) : pq[i][pq[i].size() - 1];
    rdy = mode ? 1'b1 : (fill_m[i] == stg(i));
    return {b.v, b.p, rdy, perr_m[i], b.d};
  endfunction

  function automatic logic [35:0] act_out(int unsigned i);
    case (i)
      0:       return {if0.out_vld, if0.out_par, if0.ready, if0.par_err, if0.out_data};
      1:       return {if1.out_vld, if1.out_par, if1.ready, if1.par_err, 24'h0, if1.out_data};
      default: return {if2.out_vld, if2.out_par, if2.ready, if2.par_err, 24'h0, if2.out_data};
    endcase
  endfunction

  task automatic model_reset();
    for (int unsigned i = 0; i < NI; i++) begin
      pq[i].delete();
      for (int unsigned k = 0; k < stg(i); k++) pq[i].push_front(beat_t'(0));
      fill_m[i] = 0;
      perr_m[i] = 1'b0;
    end
    mq = mode;
  endtask

  task automatic model_step();
    logic fl;
    fl = (mode != mq);
    for (int unsigned i = 0; i < NI; i++) begin
      logic [35:0] e;
      logic        err;
      e   = exp_out(i);
      err = e[35] & (^{e[31:0], e[34]});
      if (mode || !hold) begin
        if (err) perr_m[i] = 1'b1;
        else if (clr) perr_m[i] = 1'b0;
      end
      if (fl || mode || !hold) begin
        pq[i].push_front(in_beat(i));
        void'(pq[i].pop_back());
        if (fl) begin
          for (int unsigned k = 0; k < pq[i].size(); k++) begin
            beat_t t;
            t = pq[i][k];
            t.v = 1'b0;
            pq[i][k] = t;
          end
        end
      end
      if (mode || fl) fill_m[i] = 0;
      else if (!hold && fill_m[i] < stg(i)) fill_m[i] = fill_m[i] + 1;
    end
    mq = mode;
  endtask

  initial model_reset();

  always @(posedge clk or negedge arst_l) begin
    if (!arst_l) model_reset();
    else model_step();
  end

  // ---------------- checking ----------------
  task automatic chk(string name, logic [35:0] act, logic [35:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  task automatic chk_l(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%h expected=%h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int unsigned i = 0; i < NI; i++) begin
        chk($sformatf("model_u%0d", i), act_out(i), exp_out(i));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    @(posedge clk);
    #1;
    started = 1'b1;
    chk_l("rst_vld", 32'(if0.out_vld), 32'h0);
    chk_l("rst_data", if0.out_data, 32'h0);
    chk_l("rst_ready", 32'(if0.ready), 32'h0);
    chk_l("rst_perr", 32'(if0.par_err), 32'h0);

    // Bypass while in reset follows the inputs and reports ready.
    mode = 1'b1; vld = 1'b1; din = 32'h1234_5678;
    #1;
    chk_l("rst_byp_data", if0.out_data, 32'h1234_5678);
    chk_l("rst_byp_ready", 32'(if0.ready), 32'h1);
    step();
    mode = 1'b0; vld = 1'b0; din = '0;
    step();

    // Release and stream 1,2,3,...
    arst_l = 1'b1; vld = 1'b1; din = 32'h1;
    step();
    chk_l("s2_e1_ready", 32'(if0.ready), 32'h0);
    chk_l("s2_e1_vld", 32'(if0.out_vld), 32'h0);
    chk_l("s1_e1_data", 32'(if1.out_data), 32'h1);
    chk_l("s1_e1_ready", 32'(if1.ready), 32'h1);
    chk_l("s4_e1_ready", 32'(if2.ready), 32'h0);
    din = 32'h2;
    step();
    chk_l("s2_lat_data", if0.out_data, 32'h1);
    chk_l("s2_lat_vld", 32'(if0.out_vld), 32'h1);
    chk_l("s2_ready", 32'(if0.ready), 32'h1);
    din = 32'h3;
    step();
    chk_l("s4_e3_ready", 32'(if2.ready), 32'h0);
    din = 32'h4;
    step();
    chk_l("s4_lat_data", 32'(if2.out_data), 32'h1);
    chk_l("s4_ready", 32'(if2.ready), 32'h1);
    din = 32'h5;
    step();
    din = 32'h6;
    step();
    chk_l("pre_hold", if0.out_data, 32'h5);

    // Hold three cycles with garbage on the inputs.
    hold = 1'b1; din = 32'hDEAD_BEEF;
    for (int k = 0; k < 3; k++) begin
      step();
      chk_l("hold_data", if0.out_data, 32'h5);
    end
    hold = 1'b0; din = 32'h7;
    step();
    chk_l("post_hold6", if0.out_data, 32'h6);
    din = 32'h8;
    step();
    chk_l("post_hold7", if0.out_data, 32'h7);
    for (int v = 9; v < 15; v++) begin
      din = 32'(v);
      step();
    end
    chk_l("s4_sat_ready", 32'(if2.ready), 32'h1);

    // Bypass with beats in flight; hold is ignored there.
    mode = 1'b1; din = 32'hA5A5_0F0F;
    #1;
    chk_l("byp_data", if0.out_data, 32'hA5A5_0F0F);
    chk_l("byp_vld", 32'(if0.out_vld), 32'h1);
    chk_l("byp_ready", 32'(if0.ready), 32'h1);
    for (int k = 0; k < 5; k++) begin
      step();
      din  = 32'h100 + 32'(k);
      vld  = k[0];
      hold = (k == 2);
    end
    hold = 1'b0;

    // Back to pipe: two bubble cycles, then data resumes.
    mode = 1'b0; vld = 1'b1; din = 32'h200;
    step();
    chk_l("flush_e0_vld", 32'(if0.out_vld), 32'h0);
    chk_l("flush_e0_ready", 32'(if0.ready), 32'h0);
    din = 32'h201;
    step();
    chk_l("flush_e1_vld", 32'(if0.out_vld), 32'h0);
    chk_l("flush_e1_ready", 32'(if0.ready), 32'h0);
    din = 32'h202;
    step();
    chk_l("flush_e2_vld", 32'(if0.out_vld), 32'h1);
    chk_l("flush_e2_data", if0.out_data, 32'h201);
    chk_l("flush_e2_ready", 32'(if0.ready), 32'h1);
    for (int k = 0; k < 3; k++) begin
      din = 32'h300 + 32'(k);
      step();
    end

    // Parity error, sticky, then a lone clear.
    din = 32'h1; bad = 1'b1;
    step();
    din = 32'h10; bad = 1'b0;
    step();
    chk_l("perr_beat_out", if0.out_data, 32'h1);
    chk_l("perr_not_yet", 32'(if0.par_err), 32'h0);
    step();
    chk_l("perr_set", 32'(if0.par_err), 32'h1);
    step();
    chk_l("perr_sticky", 32'(if0.par_err), 32'h1);
    step();
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_l("perr_clr", 32'(if0.par_err), 32'h0);

    // Clear together with a new bad beat: set wins.
    din = 32'h1; bad = 1'b1;
    step();
    din = 32'h11; bad = 1'b0;
    step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    chk_l("perr_set_wins", 32'(if0.par_err), 32'h1);
    step();
    step();

    // Asynchronous reset mid-stream.
    chk_l("pre_arst_vld", 32'(if0.out_vld), 32'h1);
    @(posedge clk);
    #3;
    arst_l = 1'b0;
    #1;
    chk_l("arst_vld", 32'(if0.out_vld), 32'h0);
    chk_l("arst_data", if0.out_data, 32'h0);
    chk_l("arst_ready", 32'(if0.ready), 32'h0);
    chk_l("arst_perr", 32'(if0.par_err), 32'h0);
    din = 32'h3F;
    step();
    step();
    arst_l = 1'b1; din = 32'h40;
    step();
    chk_l("rel_e1_vld", 32'(if0.out_vld), 32'h0);
    din = 32'h41;
    step();
    chk_l("rel_e2_vld", 32'(if0.out_vld), 32'h1);
    chk_l("rel_e2_data", if0.out_data, 32'h40);

    // Mode toggled every cycle: a flush on every edge.
    for (int k = 0; k < 4; k++) begin
      mode = ~mode;
      din  = 32'h500 + 32'(k);
      step();
    end
    mode = 1'b0;
    for (int k = 0; k < 6; k++) begin
      din = 32'h600 + 32'(k);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
